multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 84 ++++++++
 rtl/multicycle_controller_output_decoder.sv | 88 ++++++++
 rtl/multicycle_controller.sv | 90 +++++++++
 tb/tb_multicycle_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// datapath select encodings and the bundled control-word type.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_ADR = 4'd3,
    S_MEM_RD  = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_R_EXEC  = 4'd7,
    S_R_WB    = 4'd8,
    S_BRANCH  = 4'd9,
    S_I_EXEC  = 4'd10,
    S_I_WB    = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU B-operand select
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // PC source select (2'b11 is reserved and never driven)
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Register write-data select
  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  // Register write-address select
  localparam logic [1:0] WR_RT = 2'b00;
  localparam logic [1:0] WR_RD = 2'b01;
  localparam logic [1:0] WR_RA = 2'b10;

  // ALU operation
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_LW, OP_SW: is_legal = 1'b1;
      default:               is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_output_decoder.sv
// Combinational control-word decode from the registered state. The only
// opcode dependence is in DECODE, BRANCH and JUMP, where the opcode is
// already stable.
module mc_output_decoder
  import multicycle_controller_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  // Per-state strobe and select decode; unlisted outputs stay 0.
  always_comb begin
    // NOTE: default the whole word first so no path leaves a field unassigned (no latch).
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read   = 1'b1;
        ctrl.i_or_d     = 1'b0;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_ADD;
        ctrl.pc_src     = PC_SRC_ALU;
        ctrl.pc_write   = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRC_B_IMM_SH2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !is_legal(opcode);
      end
      S_MEM_ADR, S_I_EXEC: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read   = 1'b1;
        ctrl.i_or_d     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_dst    = WR_RT;
        ctrl.mem_to_reg = WD_MDR;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRC_B_REG;
        ctrl.alu_op     = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst    = WR_RD;
        ctrl.mem_to_reg = WD_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRC_B_REG;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PC_SRC_ALUOUT;
        ctrl.branch_eq  = (opcode == OP_BEQ);
        ctrl.branch_ne  = (opcode == OP_BNE);
      end
      S_I_WB: begin
        ctrl.reg_dst    = WR_RT;
        ctrl.mem_to_reg = WD_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.pc_write   = 1'b1;
        if (opcode == OP_JAL) begin
          ctrl.reg_dst    = WR_RA;
          ctrl.mem_to_reg = WD_PC;
          ctrl.reg_write  = 1'b1;
        end
      end
      default: ;  // RST and any unlisted code: everything 0
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: state register and next-state logic live
// here; the Moore output decode is in mc_output_decoder. Because the
// outputs decode only from the state register, asserting rst_n low clears
// every strobe immediately through the asynchronous state reset.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] mem_to_reg,
  output logic [1:0] reg_dst,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_r;
  ctrl_t  ctrl;

  // State register with next-state selection; reset parks in RST so the
  // release cycle asserts no write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_r <= S_RST;
    end else begin
      case (state_r)
        S_RST:     state_r <= S_FETCH;
        S_FETCH:   state_r <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW:   state_r <= S_MEM_ADR;
            OP_RTYPE:       state_r <= S_R_EXEC;
            OP_BEQ, OP_BNE: state_r <= S_BRANCH;
            OP_ADDI:        state_r <= S_I_EXEC;
            OP_J, OP_JAL:   state_r <= S_JUMP;
            default:        state_r <= S_FETCH;  // illegal: flagged in decode
          endcase
        end
        S_MEM_ADR: state_r <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  state_r <= S_MEM_WB;
        S_MEM_WB:  state_r <= S_FETCH;
        S_MEM_WR:  state_r <= S_FETCH;
        S_R_EXEC:  state_r <= S_R_WB;
        S_R_WB:    state_r <= S_FETCH;
        S_BRANCH:  state_r <= S_FETCH;
        S_I_EXEC:  state_r <= S_I_WB;
        S_I_WB:    state_r <= S_FETCH;
        S_JUMP:    state_r <= S_FETCH;
        default:   state_r <= S_RST;   // recover from any unlisted code
      endcase
    end
  end

  mc_output_decoder u_output_decoder (
    .state  (state_r),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign pc_write   = ctrl.pc_write;
  assign branch_eq  = ctrl.branch_eq;
  assign branch_ne  = ctrl.branch_ne;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_op     = ctrl.alu_op;
  assign illegal_op = ctrl.illegal_op;
  assign state      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is
// expanded into its expected cycle-by-cycle trace by an instruction-level
// model, then compared against the DUT on the falling clock edge.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src, mem_to_reg, reg_dst, alu_op;
  logic [3:0] state;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .pc_write   (pc_write),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic [1:0] alu_op;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    outs_t      o;
    string      name;
  } step_t;

  outs_t obs;
  assign obs = {pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
                ir_write, reg_write, alu_src_a, alu_src_b, pc_src, mem_to_reg,
                reg_dst, alu_op, illegal_op};

  int    checks   = 0;
  int    failures = 0;
  step_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic step_t mk(input state_t st, input outs_t o, input string n);
    step_t s;
    s.st = st;
    s.o = o;
    s.name = n;
    return s;
  endfunction

  // Instruction-level model: expected trace from FETCH up to (not incl.)
  // the next FETCH.
  task automatic build(input logic [5:0] op);
    outs_t o;
    exp_q.delete();
    o = '0; o.mem_read = 1; o.ir_write = 1; o.alu_src_b = 2'b01; o.pc_write = 1;
    exp_q.push_back(mk(S_FETCH, o, "fetch"));
    o = '0; o.alu_src_b = 2'b11;
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
      6'b001000, 6'b000010, 6'b000011: o.illegal_op = 0;
      default: o.illegal_op = 1;
    endcase
    exp_q.push_back(mk(S_DECODE, o, "decode"));
    case (op)
      6'b100011: begin  // lw
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10;
        exp_q.push_back(mk(S_MEM_ADR, o, "lw_adr"));
        o = '0; o.mem_read = 1; o.i_or_d = 1;
        exp_q.push_back(mk(S_MEM_RD, o, "lw_rd"));
        o = '0; o.mem_to_reg = 2'b01; o.reg_write = 1;
        exp_q.push_back(mk(S_MEM_WB, o, "lw_wb"));
      end
      6'b101011: begin  // sw
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10;
        exp_q.push_back(mk(S_MEM_ADR, o, "sw_adr"));
        o = '0; o.mem_write = 1; o.i_or_d = 1;
        exp_q.push_back(mk(S_MEM_WR, o, "sw_wr"));
      end
      6'b000000: begin  // R-type
        o = '0; o.alu_src_a = 1; o.alu_op = 2'b10;
        exp_q.push_back(mk(S_R_EXEC, o, "r_exec"));
        o = '0; o.reg_dst = 2'b01; o.reg_write = 1;
        exp_q.push_back(mk(S_R_WB, o, "r_wb"));
      end
      6'b000100, 6'b000101: begin  // beq / bne
        o = '0; o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01;
        o.branch_eq = (op == 6'b000100);
        o.branch_ne = (op == 6'b000101);
        exp_q.push_back(mk(S_BRANCH, o, "branch"));
      end
      6'b001000: begin  // addi
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10;
        exp_q.push_back(mk(S_I_EXEC, o, "i_exec"));
        o = '0; o.reg_write = 1;
        exp_q.push_back(mk(S_I_WB, o, "i_wb"));
      end
      6'b000010, 6'b000011: begin  // j / jal
        o = '0; o.pc_src = 2'b10; o.pc_write = 1;
        if (op == 6'b000011) begin
          o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.reg_write = 1;
        end
        exp_q.push_back(mk(S_JUMP, o, "jump"));
      end
      default: ;  // illegal: straight back to FETCH
    endcase
  endtask

  task automatic check_step(input step_t s, input int idx);
    check($sformatf("%s[%0d].state", s.name, idx), 32'(state), 32'(s.st));
    check($sformatf("%s[%0d].outs", s.name, idx), 32'(obs), 32'(s.o));
  endtask

  // Runs one instruction: opcode applied during FETCH, checked every cycle.
  task automatic run_instr(input logic [5:0] op, input int idx);
    build(op);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check_step(exp_q[i], idx);
      if (i == 0) opcode = op;
    end
  endtask

  logic [5:0] legal_ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b000101, 6'b001000, 6'b000010, 6'b000011};

  initial begin
    logic [31:0] r;
    logic [5:0]  op;
    step_t       rst_step;
    rst_step = mk(S_RST, '0, "reset");

    // Reset state and release cycle
    rst_n  = 1'b0;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_step(rst_step, 0);
    rst_n = 1'b1;
    #1;
    check_step(rst_step, 1);

    // Directed: lw, sw, beq, bne, jal, j, illegal 111111
    run_instr(6'b100011, 0);
    run_instr(6'b101011, 1);
    run_instr(6'b000100, 2);
    run_instr(6'b000101, 3);
    run_instr(6'b000011, 4);
    run_instr(6'b000010, 5);
    run_instr(6'b111111, 6);
    run_instr(6'b000000, 7);
    run_instr(6'b001000, 8);

    // Randomised mix of legal and arbitrary opcodes
    for (int n = 0; n < 150; n++) begin
      r = $urandom();
      if (r[31:28] < 4'd10) op = legal_ops[r[2:0]];
      else                  op = r[13:8];
      run_instr(op, 100 + n);
    end

    // Reset asserted in the middle of MEM_WR
    build(6'b101011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_step(exp_q[i], 900);
      if (i == 0) opcode = 6'b101011;
    end
    #2 rst_n = 1'b0;
    #1;
    check_step(rst_step, 901);
    @(posedge clk);
    @(negedge clk);
    check_step(rst_step, 902);
    rst_n = 1'b1;
    #1;
    check_step(rst_step, 903);

    // Clean recovery: FETCH follows, then a full lw and a trailing FETCH
    run_instr(6'b100011, 904);
    build(6'b000000);
    @(negedge clk);
    check_step(exp_q[0], 905);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
